// File: rtl/ahb_slave_resp_mux.sv
// AHB-Lite slave-to-master response mux with registered data-phase select, built-in default slave and wait-state watchdog.
// Latency: data phase one cycle after accepted address phase, zero-cycle combinational muxing; backpressure: Hready_out low holds state and select.
module ahb_slave_resp_mux #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             Hclk,
    input  logic                             Hresetn,
    input  logic [NUM_SLAVES-1:0]            Hsel_vec,
    input  logic [1:0]                       Htrans,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Hrdata_bus,
    input  logic [NUM_SLAVES-1:0]            Hready_out_bus,
    input  logic [NUM_SLAVES-1:0]            Hresp_bus,
    input  logic                             timeout_clr,
    output logic [DATA_WIDTH-1:0]            Hrdata,
    output logic                             Hready_out,
    output logic                             Hresp,
    output logic                             timeout_flag
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int HIT_W = $clog2(NUM_SLAVES + 1);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_DEF,
        ST_SLAVE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  dsel;
    logic [SEL_W-1:0]  dsel_nxt;
    logic [HIT_W-1:0]  hit_cnt;
    logic [SEL_W-1:0]  hit_idx;
    logic              trans_active;
    logic              capture;
    logic [DATA_WIDTH-1:0] lane_dat;
    logic              lane_rdy;
    logic              lane_resp;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_inc;
    logic              wd_hit;

    assign trans_active = (Htrans == 2'b10) || (Htrans == 2'b11);

    // Population count and index of the decoder select; index is only used when exactly one bit is set.
    always_comb begin
        hit_cnt = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (Hsel_vec[i]) begin
                hit_cnt = hit_cnt + HIT_W'(1);
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        lane_dat  = '0;
        lane_rdy  = 1'b0;
        lane_resp = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == SEL_W'(i)) begin
                lane_dat  = Hrdata_bus[i*DATA_WIDTH +: DATA_WIDTH];
                lane_rdy  = Hready_out_bus[i];
                lane_resp = Hresp_bus[i];
            end
        end
    end

    always_comb begin
        Hrdata     = '0;
        Hready_out = 1'b1;
        Hresp      = 1'b0;
        case (state)
            ST_SLAVE: begin
                Hrdata     = lane_dat;
                Hready_out = lane_rdy;
                Hresp      = lane_resp;
            end
            ST_ERR1: begin
                Hready_out = 1'b0;
                Hresp      = 1'b1;
            end
            ST_ERR2: begin
                Hresp      = 1'b1;
            end
            default: ;
        endcase
    end

    assign capture = Hready_out && (state != ST_ERR1);

    always_comb begin
        state_nxt = state;
        dsel_nxt  = dsel;
        if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end else if (capture) begin
            if (!trans_active) begin
                state_nxt = ST_DEF;
            end else if (hit_cnt == HIT_W'(1)) begin
                state_nxt = ST_SLAVE;
                dsel_nxt  = hit_idx;
            end else begin
                state_nxt = ST_ERR1;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= ST_DEF;
            dsel  <= '0;
        end else begin
            state <= state_nxt;
            dsel  <= dsel_nxt;
        end
    end

    // With TIMEOUT=0 CNT_MAX is 0, so the counter never moves and wd_hit never fires.
    assign wait_inc = (state == ST_SLAVE) && !Hready_out && (wait_cnt != CNT_MAX);
    assign wd_hit   = wait_inc && (wait_cnt == CNT_MAX - CNT_W'(1));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (capture) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (wd_hit) begin
                timeout_flag <= 1'b1;
            end else if (timeout_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Bench for ahb_slave_resp_mux: directed scenarios plus randomized traffic against a transfer-level reference model,
// with extra instances sweeping NUM_SLAVES=1/3/8 and DATA_WIDTH=64.
module tb_ahb_slave_resp_mux;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int K_DEF  = 0;
    localparam int K_SLV  = 1;
    localparam int K_ERR1 = 2;
    localparam int K_ERR2 = 3;

    logic           Hclk;
    logic           Hresetn;
    logic [NS-1:0]  Hsel_vec;
    logic [1:0]     Htrans;
    logic [NS*DW-1:0] Hrdata_bus;
    logic [NS-1:0]  Hready_out_bus;
    logic [NS-1:0]  Hresp_bus;
    logic           timeout_clr;
    logic [DW-1:0]  Hrdata;
    logic           Hready_out;
    logic           Hresp;
    logic           timeout_flag;

    logic [0:0]     s1;
    logic [31:0]    rb1;
    logic [31:0]    d1;
    logic           r1, p1, f1;
    logic [2:0]     s3;
    logic [191:0]   rb3;
    logic [63:0]    d3;
    logic           r3, p3, f3;
    logic [7:0]     s8;
    logic [255:0]   rb8;
    logic [31:0]    d8;
    logic           r8, p8, f8;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: what kind of data phase is currently on the bus.
    int         m_kind, m_sel, m_wait;
    logic       m_flag;
    logic       e_rdy, e_resp;
    logic [DW-1:0] e_dat;

    ahb_slave_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel_vec(Hsel_vec), .Htrans(Htrans),
        .Hrdata_bus(Hrdata_bus), .Hready_out_bus(Hready_out_bus), .Hresp_bus(Hresp_bus),
        .timeout_clr(timeout_clr), .Hrdata(Hrdata), .Hready_out(Hready_out),
        .Hresp(Hresp), .timeout_flag(timeout_flag)
    );

    ahb_slave_resp_mux #(.NUM_SLAVES(1), .DATA_WIDTH(32), .TIMEOUT(0)) u1 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel_vec(s1), .Htrans(Htrans),
        .Hrdata_bus(rb1), .Hready_out_bus('1), .Hresp_bus('0),
        .timeout_clr(timeout_clr), .Hrdata(d1), .Hready_out(r1),
        .Hresp(p1), .timeout_flag(f1)
    );

    ahb_slave_resp_mux #(.NUM_SLAVES(3), .DATA_WIDTH(64), .TIMEOUT(16)) u3 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel_vec(s3), .Htrans(Htrans),
        .Hrdata_bus(rb3), .Hready_out_bus('1), .Hresp_bus('0),
        .timeout_clr(timeout_clr), .Hrdata(d3), .Hready_out(r3),
        .Hresp(p3), .timeout_flag(f3)
    );

    ahb_slave_resp_mux #(.NUM_SLAVES(8), .DATA_WIDTH(32), .TIMEOUT(16)) u8 (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hsel_vec(s8), .Htrans(Htrans),
        .Hrdata_bus(rb8), .Hready_out_bus('1), .Hresp_bus('0),
        .timeout_clr(timeout_clr), .Hrdata(d8), .Hready_out(r8),
        .Hresp(p8), .timeout_flag(f8)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic model_reset();
        m_kind = K_DEF;
        m_sel  = 0;
        m_wait = 0;
        m_flag = 1'b0;
    endtask

    task automatic calc_exp();
        e_rdy  = 1'b1;
        e_resp = 1'b0;
        e_dat  = '0;
        if (m_kind == K_SLV) begin
            e_rdy  = Hready_out_bus[m_sel];
            e_resp = Hresp_bus[m_sel];
            e_dat  = Hrdata_bus[m_sel*DW +: DW];
        end else if (m_kind == K_ERR1) begin
            e_rdy  = 1'b0;
            e_resp = 1'b1;
        end else if (m_kind == K_ERR2) begin
            e_resp = 1'b1;
        end
    endtask

    // One bus cycle: evaluate the model on the pre-edge inputs, cross the edge, land on the falling edge.
    task automatic adv();
        int   n_kind, n_sel, n_wait;
        logic n_flag;
        calc_exp();
        n_kind = m_kind;
        n_sel  = m_sel;
        n_wait = m_wait;
        n_flag = m_flag;
        if (m_kind == K_ERR1) begin
            n_kind = K_ERR2;
        end else if (e_rdy) begin
            n_wait = 0;
            if (!Htrans[1]) begin
                n_kind = K_DEF;
            end else if ($countones(Hsel_vec) == 1) begin
                n_kind = K_SLV;
                for (int i = 0; i < NS; i++) if (Hsel_vec == NS'(1 << i)) n_sel = i;
            end else begin
                n_kind = K_ERR1;
            end
        end else if (m_wait < TMO) begin
            n_wait = m_wait + 1;
        end
        if (n_wait == TMO && m_wait != TMO) n_flag = 1'b1;
        else if (timeout_clr) n_flag = 1'b0;
        @(posedge Hclk);
        if (Hresetn) begin
            m_kind = n_kind;
            m_sel  = n_sel;
            m_wait = n_wait;
            m_flag = n_flag;
        end else begin
            model_reset();
        end
        @(negedge Hclk);
    endtask

    task automatic set_lanes();
        for (int i = 0; i < NS; i++) Hrdata_bus[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (Hready_out !== 1'b1) $display("FAIL reset_rdy: got %b expected 1", Hready_out); else n_pass++;
        n_chk++; if (Hresp !== 1'b0) $display("FAIL reset_resp: got %b expected 0", Hresp); else n_pass++;
        n_chk++; if (Hrdata !== '0) $display("FAIL reset_dat: got %h expected 0", Hrdata); else n_pass++;
        n_chk++; if (timeout_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", timeout_flag); else n_pass++;
        @(negedge Hclk);
        Hresetn = 1'b1;
        set_lanes();
        Htrans = 2'b10; Hsel_vec = 4'b0100; Hready_out_bus = '1;
        adv();
        Htrans = 2'b00; Hsel_vec = '0; Hready_out_bus[2] = 1'b0;
        #1;
        n_chk++; if (Hready_out !== 1'b0) $display("FAIL stall_before_reset: got %b expected 0", Hready_out); else n_pass++;
        #1 Hresetn = 1'b0;
        #1;
        n_chk++; if (Hready_out !== 1'b1) $display("FAIL async_reset_rdy: got %b expected 1", Hready_out); else n_pass++;
        n_chk++; if (Hresp !== 1'b0) $display("FAIL async_reset_resp: got %b expected 0", Hresp); else n_pass++;
        n_chk++; if (Hrdata !== '0) $display("FAIL async_reset_dat: got %h expected 0", Hrdata); else n_pass++;
        n_chk++; if (timeout_flag !== 1'b0) $display("FAIL async_reset_flag: got %b expected 0", timeout_flag); else n_pass++;
        model_reset();
        @(negedge Hclk);
        Hresetn = 1'b1;
        Hready_out_bus = '1;
    endtask

    task automatic test_steering();
        logic exp_r;
        for (int i = 0; i < NS; i++) begin
            set_lanes();
            Htrans = 2'b10; Hsel_vec = NS'(1 << i); Hready_out_bus = '1; Hresp_bus = '0;
            adv();
            Htrans = 2'b00; Hsel_vec = '0; Hready_out_bus = NS'($urandom);
            exp_r = Hready_out_bus[i];
            #1;
            n_chk++; if (Hrdata !== 32'hA5A5_0000 + 32'(i))
                $display("FAIL steer_dat[%0d]: got %h expected %h", i, Hrdata, 32'hA5A5_0000 + 32'(i)); else n_pass++;
            n_chk++; if (Hready_out !== exp_r)
                $display("FAIL steer_rdy[%0d]: got %b expected %b", i, Hready_out, exp_r); else n_pass++;
            Hready_out_bus = '1;
            adv();
        end
    endtask

    task automatic test_wait_states();
        set_lanes();
        Htrans = 2'b10; Hsel_vec = 4'b0010; Hready_out_bus = '1;
        adv();
        Hready_out_bus[1] = 1'b0; Htrans = 2'b10; Hsel_vec = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (Hready_out !== 1'b0) $display("FAIL wait_rdy[%0d]: got %b expected 0", k, Hready_out); else n_pass++;
            n_chk++; if (Hrdata !== 32'hA5A5_0001) $display("FAIL wait_dat[%0d]: got %h expected a5a50001", k, Hrdata); else n_pass++;
            adv();
        end
        Hready_out_bus[1] = 1'b1;
        #1;
        n_chk++; if (Hready_out !== 1'b1) $display("FAIL wait_release_rdy: got %b expected 1", Hready_out); else n_pass++;
        n_chk++; if (Hrdata !== 32'hA5A5_0001) $display("FAIL wait_release_dat: got %h expected a5a50001", Hrdata); else n_pass++;
        adv();
        Htrans = 2'b00; Hsel_vec = '0;
        #1;
        n_chk++; if (Hrdata !== 32'hA5A5_0003) $display("FAIL next_slave_dat: got %h expected a5a50003", Hrdata); else n_pass++;
        n_chk++; if (Hready_out !== 1'b1) $display("FAIL next_slave_rdy: got %b expected 1", Hready_out); else n_pass++;
        adv();
    endtask

    task automatic test_default_slave();
        Htrans = 2'b10; Hsel_vec = 4'b0000;
        adv();
        Htrans = 2'b10; Hsel_vec = 4'b0001;  // must be ignored while in the first error cycle
        #1;
        n_chk++; if ({Hready_out, Hresp} !== 2'b01) $display("FAIL err0_c1: got rdy/resp %b expected 01", {Hready_out, Hresp}); else n_pass++;
        n_chk++; if (Hrdata !== '0) $display("FAIL err0_dat: got %h expected 0", Hrdata); else n_pass++;
        adv();
        Htrans = 2'b10; Hsel_vec = 4'b0110;
        #1;
        n_chk++; if ({Hready_out, Hresp} !== 2'b11) $display("FAIL err0_c2: got rdy/resp %b expected 11", {Hready_out, Hresp}); else n_pass++;
        adv();
        Htrans = 2'b00; Hsel_vec = '0;
        #1;
        n_chk++; if ({Hready_out, Hresp} !== 2'b01) $display("FAIL errmulti_c1: got rdy/resp %b expected 01", {Hready_out, Hresp}); else n_pass++;
        adv();
        #1;
        n_chk++; if ({Hready_out, Hresp} !== 2'b11) $display("FAIL errmulti_c2: got rdy/resp %b expected 11", {Hready_out, Hresp}); else n_pass++;
        adv();
        #1;
        n_chk++; if ({Hready_out, Hresp} !== 2'b10) $display("FAIL idle_okay: got rdy/resp %b expected 10", {Hready_out, Hresp}); else n_pass++;
        n_chk++; if (Hrdata !== '0) $display("FAIL idle_dat: got %h expected 0", Hrdata); else n_pass++;
    endtask

    task automatic stall_slave2(input int cycles);
        Htrans = 2'b10; Hsel_vec = 4'b0100; Hready_out_bus = '1;
        adv();
        Htrans = 2'b00; Hsel_vec = '0; Hready_out_bus[2] = 1'b0;
        repeat (cycles) adv();
    endtask

    task automatic test_watchdog();
        timeout_clr = 1'b1;
        adv();
        timeout_clr = 1'b0;
        stall_slave2(15);
        #1;
        n_chk++; if (timeout_flag !== 1'b0) $display("FAIL wd_15: got %b expected 0", timeout_flag); else n_pass++;
        Hready_out_bus[2] = 1'b1;
        adv();
        stall_slave2(16);
        #1;
        n_chk++; if (timeout_flag !== 1'b1) $display("FAIL wd_16: got %b expected 1", timeout_flag); else n_pass++;
        timeout_clr = 1'b1;
        adv();
        timeout_clr = 1'b0;
        adv();
        #1;
        n_chk++; if (timeout_flag !== 1'b0) $display("FAIL wd_clr_saturated: got %b expected 0", timeout_flag); else n_pass++;
        Hready_out_bus[2] = 1'b1;
        adv();
        stall_slave2(15);
        timeout_clr = 1'b1;
        adv();
        timeout_clr = 1'b0;
        #1;
        n_chk++; if (timeout_flag !== 1'b1) $display("FAIL wd_set_wins: got %b expected 1", timeout_flag); else n_pass++;
        Hready_out_bus[2] = 1'b1;
        repeat (3) adv();
        #1;
        n_chk++; if (timeout_flag !== 1'b1) $display("FAIL wd_sticky: got %b expected 1", timeout_flag); else n_pass++;
        timeout_clr = 1'b1;
        adv();
        timeout_clr = 1'b0;
        #1;
        n_chk++; if (timeout_flag !== 1'b0) $display("FAIL wd_late_clr: got %b expected 0", timeout_flag); else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            Htrans = 2'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7) Hsel_vec = NS'(1 << $urandom_range(0, NS - 1));
            else if (r == 7) Hsel_vec = '0;
            else Hsel_vec = NS'($urandom);
            for (int i = 0; i < NS; i++) begin
                Hready_out_bus[i] = ($urandom_range(0, 3) != 0);
                Hresp_bus[i]      = ($urandom_range(0, 7) == 0);
                Hrdata_bus[i*DW +: DW] = $urandom;
            end
            timeout_clr = ($urandom_range(0, 15) == 0);
            #1;
            calc_exp();
            n_chk++; if (Hready_out !== e_rdy) $display("FAIL rand_rdy[%0d]: got %b expected %b", c, Hready_out, e_rdy); else n_pass++;
            n_chk++; if (Hresp !== e_resp) $display("FAIL rand_resp[%0d]: got %b expected %b", c, Hresp, e_resp); else n_pass++;
            n_chk++; if (Hrdata !== e_dat) $display("FAIL rand_dat[%0d]: got %h expected %h", c, Hrdata, e_dat); else n_pass++;
            n_chk++; if (timeout_flag !== m_flag) $display("FAIL rand_flag[%0d]: got %b expected %b", c, timeout_flag, m_flag); else n_pass++;
            adv();
        end
        timeout_clr = 1'b0;
    endtask

    task automatic test_sweep();
        logic [63:0] x3;
        logic [31:0] x1;
        logic        xr3, xp3, xr1;
        rb1 = 32'h1111_0000;
        for (int i = 0; i < 3; i++) rb3[i*64 +: 64] = {32'hDEAD_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)};
        for (int i = 0; i < 8; i++) rb8[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        Htrans = 2'b00; Hsel_vec = '0; Hready_out_bus = '1;
        repeat (3) adv();
        for (int i = 0; i < 8; i++) begin
            Htrans = 2'b10;
            s8 = 8'(1 << i);
            s3 = (i < 3) ? 3'(1 << i) : 3'b000;
            s1 = (i == 0) ? 1'b1 : 1'b0;
            adv();
            Htrans = 2'b00; s8 = '0; s3 = '0; s1 = '0;
            x3  = (i < 3) ? {32'hDEAD_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)} : 64'h0;
            xr3 = (i < 3);
            xp3 = (i >= 3);
            x1  = (i == 0) ? 32'h1111_0000 : 32'h0;
            xr1 = (i == 0);
            #1;
            n_chk++; if (d8 !== 32'hC0DE_0000 + 32'(i)) $display("FAIL n8_dat[%0d]: got %h expected %h", i, d8, 32'hC0DE_0000 + 32'(i)); else n_pass++;
            n_chk++; if ({r8, p8} !== 2'b10) $display("FAIL n8_rdy_resp[%0d]: got %b expected 10", i, {r8, p8}); else n_pass++;
            n_chk++; if (d3 !== x3) $display("FAIL n3_dat[%0d]: got %h expected %h", i, d3, x3); else n_pass++;
            n_chk++; if ({r3, p3} !== {xr3, xp3}) $display("FAIL n3_rdy_resp[%0d]: got %b expected %b", i, {r3, p3}, {xr3, xp3}); else n_pass++;
            n_chk++; if (d1 !== x1) $display("FAIL n1_dat[%0d]: got %h expected %h", i, d1, x1); else n_pass++;
            n_chk++; if (r1 !== xr1) $display("FAIL n1_rdy[%0d]: got %b expected %b", i, r1, xr1); else n_pass++;
            adv();
            adv();
        end
    endtask

    initial begin
        Hresetn = 1'b1;
        Htrans = 2'b00; Hsel_vec = '0; Hrdata_bus = '0; Hready_out_bus = '1; Hresp_bus = '0;
        timeout_clr = 1'b0;
        s1 = '0; s3 = '0; s8 = '0; rb1 = '0; rb3 = '0; rb8 = '0;
        model_reset();
        #1 Hresetn = 1'b0;
        test_reset();
        test_steering();
        test_wait_states();
        test_default_slave();
        test_watchdog();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
